edge_detect_mc: RTL and testbench
=================================

Name: edge_detect_mc

Overview:
Multi-channel edge detector. Each channel has an input synchroniser, a glitch filter and per-channel mode select (rise/fall/both/off). It also provides sticky flags and saturating event counters. It succeeds the single-channel edge detector and sits between asynchronous status/strobe inputs and control logic or register-mapped status.

Parameters:
CH, 4, number of independent channels (>=1)
SYNC_STAGES, 2, synchroniser flops per channel (>=2)
FILT_LEN, 3, consecutive cycles a synced level must differ from the filtered level before it is accepted (>=1)
CNT_W, 8, event counter width per channel (>=1)
REG_EVENT, 1, 1 = registered edge outputs, 0 = combinational edge outputs

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
init_n  in  1  synchronous re-initialise, active-low
data_in  in  CH  asynchronous channel inputs
mode  in  2*CH  per channel [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both
clr_sticky  in  CH  synchronous clear of sticky[i]
clr_cnt  in  CH  synchronous clear of evt_cnt[i] and cnt_sat[i]
level_out  out  CH  filtered level
edge_out  out  CH  one-cycle pulse on a qualified edge (mode-gated)
edge_rise  out  CH  one-cycle pulse on a filtered rising edge (not mode-gated)
edge_fall  out  CH  one-cycle pulse on a filtered falling edge (not mode-gated)
sticky  out  CH  set by edge_out[i], held until clr_sticky[i]
evt_cnt  out  CH*CNT_W  qualified edge count, channel i at [i*CNT_W +: CNT_W]
cnt_sat  out  CH  evt_cnt[i] reached all-ones

Behaviour:
- Reset (rst=1, async): every flop is cleared. That covers synchronisers, filter counters, level_out, edge pulses, sticky, evt_cnt and cnt_sat. A channel held high through reset therefore produces one rising edge after release.
- Synchroniser: SYNC_STAGES-deep shift per channel. The last stage is "synced".
- Filter:
  - Counter width is clog2(FILT_LEN) and has a minimum of 1.
  - If synced == level_out, the counter clears.
  - Otherwise the counter increments.
  - flip_next = (synced != level_out) && (counter == FILT_LEN-1).
  - On flip_next, level_out toggles at the next edge and the counter clears.
  - A pulse that differs for fewer than FILT_LEN consecutive synced cycles produces nothing.
- Edge decode:
  - rise = flip_next & !level_out; fall = flip_next & level_out.
  - qual = (rise & mode[2i]) | (fall & mode[2i+1]).
  - REG_EVENT=1: edge_out/edge_rise/edge_fall are registered and high in the same cycle level_out shows its new value.
  - REG_EVENT=0: they are combinational, one cycle earlier.
  - Pulse width is always exactly 1 cycle. Edges on one channel are separated by at least FILT_LEN cycles.
- Latency: L = SYNC_STAGES + FILT_LEN - 1 + REG_EVENT clock edges. The edge that first samples the new data_in counts as edge 1, and edge_out is high after edge L. Defaults give L=5.
- Mode:
  - mode is sampled in the flip_next cycle, so changing it mid-filter affects only pending and future edges.
  - With mode 00, level_out, edge_rise and edge_fall still operate. edge_out, sticky and evt_cnt are frozen.
- Sticky:
  - qual sets sticky and clr_sticky clears it.
  - If both occur in the same cycle, set wins and sticky=1.
- Counter:
  - qual increments evt_cnt.
  - At all-ones it holds and cnt_sat=1; no wrap.
  - clr_cnt clears both evt_cnt and cnt_sat. If clr_cnt and qual occur in the same cycle, evt_cnt=1 and cnt_sat=0 (with CNT_W=1, cnt_sat=1).
- init_n=0 (synchronous, all channels):
  - level_out loads the current synced value and the filter counters clear.
  - edge outputs, sticky, evt_cnt and cnt_sat clear.
  - No edge is produced in that cycle or from the loaded level.
  - The synchronisers keep running.
- Channels are fully independent. Simultaneous edges on all channels are all counted.

Test Plan:
1. Defaults, rst 1->0, data_in[0] 0->1 held -> edge_out[0], edge_rise[0] high 1 cycle after edge 5; level_out[0]=1; sticky[0]=1; evt_cnt[0]=1.
2. data_in[1] high for 2 cycles, FILT_LEN=3 -> no edge_rise/edge_out; level_out[1] stays 0; evt_cnt[1]=0.
3. mode[1:0]=10, data_in[0] 0->1->0 with each level held 8 cycles -> edge_rise[0] and edge_fall[0] each pulse once; edge_out[0] pulses only on the fall; evt_cnt[0]=1.
4. CNT_W=2, mode=11, 5 full toggles -> evt_cnt=3 and cnt_sat=1 after the 3rd edge, held; then clr_cnt with a same-cycle edge -> evt_cnt=1, cnt_sat=0.
5. data_in=4'hF held, rst released, then init_n pulsed low 1 cycle before edges mature -> level_out=4'hF, no edge_out, sticky=0, evt_cnt all 0.
6. REG_EVENT=0 vs 1, same stimulus -> edge_out one cycle earlier with REG_EVENT=0; rst asserted mid-filter -> all outputs 0 immediately (async).

Source files
------------

// File: rtl/edge_detect_mc.sv
// Multi-channel edge detector: per-channel synchroniser, glitch filter, mode-gated edge
// qualification, sticky flags and saturating event counters.
module edge_detect_mc #(
  parameter int unsigned CH          = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_LEN    = 3,
  parameter int unsigned CNT_W       = 8,
  parameter bit          REG_EVENT   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init_n,
  input  logic [CH-1:0]         data_in,
  input  logic [2*CH-1:0]       mode,
  input  logic [CH-1:0]         clr_sticky,
  input  logic [CH-1:0]         clr_cnt,
  output logic [CH-1:0]         level_out,
  output logic [CH-1:0]         edge_out,
  output logic [CH-1:0]         edge_rise,
  output logic [CH-1:0]         edge_fall,
  output logic [CH-1:0]         sticky,
  output logic [CH*CNT_W-1:0]   evt_cnt,
  output logic [CH-1:0]         cnt_sat
);

  localparam int unsigned FW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [FW-1:0] FiltMax = FW'(FILT_LEN - 1);

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;
    logic [FW-1:0]          fcnt_q, fcnt_d;
    logic                   level_q, level_d;
    logic                   flip, rise, fall, qual;
    logic                   sticky_q, sticky_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    assign synced = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync_q   <= '0;
        fcnt_q   <= '0;
        level_q  <= 1'b0;
        sticky_q <= 1'b0;
        cnt_q    <= '0;
      end else begin
        sync_q   <= {sync_q[SYNC_STAGES-2:0], data_in[i]};
        fcnt_q   <= fcnt_d;
        level_q  <= level_d;
        sticky_q <= sticky_d;
        cnt_q    <= cnt_d;
      end
    end

    always_comb begin
      // init_n suppresses any edge so the loaded level never produces one
      flip = init_n && (synced != level_q) && (fcnt_q == FiltMax);
      rise = flip & ~level_q;
      fall = flip & level_q;
      qual = (rise & mode[2*i]) | (fall & mode[2*i+1]);

      fcnt_d   = fcnt_q;
      level_d  = level_q;
      sticky_d = sticky_q;
      cnt_d    = cnt_q;

      if (!init_n) begin
        level_d  = synced;
        fcnt_d   = '0;
        sticky_d = 1'b0;
        cnt_d    = '0;
      end else begin
        if (synced == level_q || flip) begin
          fcnt_d = '0;
        end else begin
          fcnt_d = fcnt_q + 1'b1;
        end
        level_d = level_q ^ flip;

        if (qual) begin
          sticky_d = 1'b1;
        end else if (clr_sticky[i]) begin
          sticky_d = 1'b0;
        end

        if (clr_cnt[i]) begin
          cnt_d = CNT_W'(qual);
        end else if (qual && !(&cnt_q)) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    if (REG_EVENT) begin : g_reg
      logic eout_q, rise_q, fall_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          eout_q <= 1'b0;
          rise_q <= 1'b0;
          fall_q <= 1'b0;
        end else begin
          eout_q <= qual;
          rise_q <= rise;
          fall_q <= fall;
        end
      end

      assign edge_out[i]  = eout_q;
      assign edge_rise[i] = rise_q;
      assign edge_fall[i] = fall_q;
    end else begin : g_comb
      assign edge_out[i]  = qual;
      assign edge_rise[i] = rise;
      assign edge_fall[i] = fall;
    end

    assign level_out[i]              = level_q;
    assign sticky[i]                 = sticky_q;
    assign evt_cnt[i*CNT_W +: CNT_W] = cnt_q;
    assign cnt_sat[i]                = &cnt_q;
  end

endmodule

// File: tb/tb_edge_detect_mc.sv
// Directed bench for edge_detect_mc: default, 2-bit counter and combinational-edge variants
// share one stimulus stream.
module tb_edge_detect_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic        init_n;
  logic [3:0]  data_in;
  logic [7:0]  mode;
  logic [3:0]  clr_sticky;
  logic [3:0]  clr_cnt;

  // a_: defaults, b_: REG_EVENT=0, c_: CNT_W=2
  logic [3:0]  a_lv, a_eo, a_er, a_ef, a_st, a_cs;
  logic [31:0] a_ec;
  logic [3:0]  b_lv, b_eo, b_er, b_ef, b_st, b_cs;
  logic [31:0] b_ec;
  logic [3:0]  c_lv, c_eo, c_er, c_ef, c_st, c_cs;
  logic [7:0]  c_ec;

  int n_checks = 0;
  int n_errors = 0;

  logic mon_clr = 1'b1;
  int rise_seen, fall_seen, eout_seen, eout_any, rise_any;

  always #5 clk = ~clk;

  edge_detect_mc dut_a (
    .clk(clk), .rst(rst), .init_n(init_n), .data_in(data_in), .mode(mode),
    .clr_sticky(clr_sticky), .clr_cnt(clr_cnt), .level_out(a_lv), .edge_out(a_eo),
    .edge_rise(a_er), .edge_fall(a_ef), .sticky(a_st), .evt_cnt(a_ec), .cnt_sat(a_cs)
  );

  edge_detect_mc #(.REG_EVENT(1'b0)) dut_b (
    .clk(clk), .rst(rst), .init_n(init_n), .data_in(data_in), .mode(mode),
    .clr_sticky(clr_sticky), .clr_cnt(clr_cnt), .level_out(b_lv), .edge_out(b_eo),
    .edge_rise(b_er), .edge_fall(b_ef), .sticky(b_st), .evt_cnt(b_ec), .cnt_sat(b_cs)
  );

  edge_detect_mc #(.CNT_W(2)) dut_c (
    .clk(clk), .rst(rst), .init_n(init_n), .data_in(data_in), .mode(mode),
    .clr_sticky(clr_sticky), .clr_cnt(clr_cnt), .level_out(c_lv), .edge_out(c_eo),
    .edge_rise(c_er), .edge_fall(c_ef), .sticky(c_st), .evt_cnt(c_ec), .cnt_sat(c_cs)
  );

  always @(negedge clk) begin
    if (mon_clr) begin
      rise_seen = 0;
      fall_seen = 0;
      eout_seen = 0;
      eout_any  = 0;
      rise_any  = 0;
    end else begin
      rise_seen += int'(a_er[0]);
      fall_seen += int'(a_ef[0]);
      eout_seen += int'(a_eo[0]);
      eout_any  += int'(|a_eo) + int'(|b_eo);
      rise_any  += int'(|a_er) + int'(|b_er);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; init_n = 1'b1; data_in = 4'h0; mode = 8'hFD;
    clr_sticky = 4'h0; clr_cnt = 4'h0;
    tick(2);
    chk("rst_level", {28'b0, a_lv}, 32'h0);
    chk("rst_edge", {28'b0, a_eo | a_er | a_ef}, 32'h0);
    chk("rst_sticky", {28'b0, a_st}, 32'h0);
    chk("rst_cnt", a_ec, 32'h0);
    rst = 1'b0;
    tick(2);

    // Rising edge on ch0: latency 5 registered, 4 combinational
    data_in = 4'h1;
    tick(4);
    chk("t1_comb_eout_e4", {28'b0, b_eo}, 32'h1);
    chk("t1_reg_eout_e4", {28'b0, a_eo}, 32'h0);
    tick(1);
    chk("t1_eout", {28'b0, a_eo}, 32'h1);
    chk("t1_rise", {28'b0, a_er}, 32'h1);
    chk("t1_level", {28'b0, a_lv}, 32'h1);
    chk("t1_sticky", {28'b0, a_st}, 32'h1);
    chk("t1_cnt", a_ec, 32'h1);
    chk("t1_comb_eout_e5", {28'b0, b_eo}, 32'h0);
    tick(1);
    chk("t1_eout_width", {28'b0, a_eo}, 32'h0);

    // Short glitch on ch1 is filtered out
    data_in = 4'h3;
    tick(2);
    data_in = 4'h1;
    tick(6);
    chk("t2_level", {28'b0, a_lv}, 32'h1);
    chk("t2_cnt1", {24'b0, a_ec[15:8]}, 32'h0);
    chk("t2_sticky", {28'b0, a_st}, 32'h1);

    // Mode off freezes qualification; then fall-only mode
    mode = 8'hFC;
    data_in = 4'h0;
    tick(8);
    chk("t3_off_level", {28'b0, a_lv}, 32'h0);
    chk("t3_off_cnt", a_ec, 32'h1);
    chk("t3_off_sticky", {28'b0, a_st}, 32'h1);
    clr_cnt = 4'h1; clr_sticky = 4'h1;
    tick(1);
    clr_cnt = 4'h0; clr_sticky = 4'h0;
    chk("t3_clr_cnt", a_ec, 32'h0);
    chk("t3_clr_sticky", {28'b0, a_st}, 32'h0);
    mode = 8'hFE;
    mon_clr = 1'b1;
    tick(1);
    mon_clr = 1'b0;
    data_in = 4'h1;
    tick(8);
    data_in = 4'h0;
    tick(8);
    chk("t3_rise_seen", rise_seen, 32'd1);
    chk("t3_fall_seen", fall_seen, 32'd1);
    chk("t3_eout_seen", eout_seen, 32'd1);
    chk("t3_cnt", a_ec, 32'h1);
    chk("t3_comb_cnt", b_ec, 32'h1);

    // Saturating 2-bit counter on ch2
    for (int k = 1; k <= 5; k++) begin
      data_in[2] = !data_in[2];
      tick(6);
      if (k == 2) begin
        chk("t4_cnt_k2", {30'b0, c_ec[5:4]}, 32'd2);
        chk("t4_sat_k2", {31'b0, c_cs[2]}, 32'd0);
      end
      if (k == 3) begin
        chk("t4_cnt_k3", {30'b0, c_ec[5:4]}, 32'd3);
        chk("t4_sat_k3", {31'b0, c_cs[2]}, 32'd1);
      end
    end
    chk("t4_cnt_hold", {30'b0, c_ec[5:4]}, 32'd3);
    chk("t4_sat_hold", {31'b0, c_cs[2]}, 32'd1);
    chk("t4_wide_cnt", {24'b0, a_ec[23:16]}, 32'd5);
    data_in[2] = !data_in[2];
    tick(4);
    clr_cnt = 4'h4;
    tick(1);
    clr_cnt = 4'h0;
    chk("t4_clr_edge_eout", {31'b0, c_eo[2]}, 32'd1);
    chk("t4_clr_edge_cnt", {30'b0, c_ec[5:4]}, 32'd1);
    chk("t4_clr_edge_sat", {31'b0, c_cs[2]}, 32'd0);
    chk("t4_clr_edge_wide", {24'b0, a_ec[23:16]}, 32'd1);

    // Held high through reset, init_n loads the level before edges mature
    mon_clr = 1'b1;
    data_in = 4'hF;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    mon_clr = 1'b0;
    tick(2);
    init_n = 1'b0;
    tick(1);
    init_n = 1'b1;
    chk("t5_level", {28'b0, a_lv}, 32'hF);
    chk("t5_comb_level", {28'b0, b_lv}, 32'hF);
    tick(6);
    chk("t5_no_eout", eout_any, 32'd0);
    chk("t5_no_rise", rise_any, 32'd0);
    chk("t5_sticky", {28'b0, a_st}, 32'h0);
    chk("t5_cnt", a_ec, 32'h0);

    // Simultaneous falls, then async reset mid-filter
    data_in = 4'h0;
    tick(6);
    chk("t6_all_cnt", a_ec, 32'h01010101);
    chk("t6_all_sticky", {28'b0, a_st}, 32'hF);
    data_in = 4'hF;
    tick(3);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_level", {28'b0, a_lv}, 32'h0);
    chk("t6_async_sticky", {28'b0, a_st}, 32'h0);
    chk("t6_async_cnt", a_ec, 32'h0);
    chk("t6_async_sat", {28'b0, c_cs}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mode = 8'hFF;
    tick(4);
    chk("t6_comb_eout", {28'b0, b_eo}, 32'hF);
    chk("t6_reg_eout_early", {28'b0, a_eo}, 32'h0);
    tick(1);
    chk("t6_reg_eout", {28'b0, a_eo}, 32'hF);
    chk("t6_rise", {28'b0, a_er}, 32'hF);
    chk("t6_level", {28'b0, a_lv}, 32'hF);
    chk("t6_cnt", a_ec, 32'h01010101);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
